// File: rtl/candy_if_prefetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch prefetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package candy_if_prefetch_pkg;

   // Default SRAM geometry of the instruction memory port
   localparam int SRAM_ADDR_WIDTH = 17;
   localparam int SRAM_DATA_WIDTH = 24;

   // Read-request levels on the SRAM port
   localparam logic READ_ENABLE  = 1'b1;
   localparam logic READ_DISABLE = 1'b0;

   // Reset is asserted when the reset pin sits at this level
   localparam logic RST_ACTIVE_LVL = 1'b0;

   // Fetch FSM: IDLE = nothing outstanding, FETCH = outstanding and wanted,
   // DISCARD = outstanding but made stale by a redirect
   typedef enum logic [1:0] {
      IF_IDLE    = 2'b00,
      IF_FETCH   = 2'b01,
      IF_DISCARD = 2'b10
   } if_state_e;

endpackage

// File: rtl/candy_if_prefetch_fifo.sv
// Small prefetch FIFO holding {pc, inst} pairs with synchronous clear.
// Latency: push visible at the head right after the push edge; head read from registered storage.
// Backpressure: push is ignored when full (callers reserve space); pop when empty is a no-op.
module candy_if_prefetch_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_dat_i,
   input  logic                   pop_i,
   output logic                   head_vld_o,
   output logic [WIDTH-1:0]       head_dat_o,
   output logic [$clog2(DEPTH):0] count_o
);
   import candy_if_prefetch_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_pop;
   logic             do_push;

   // A pop frees the slot in the same cycle, so push-while-full-and-popping is legal
   assign do_pop  = pop_i && (count_q != '0) && !clear_i;
   assign do_push = push_i && ((count_q != FULL_CNT) || do_pop) && !clear_i;

   // Entry storage; cleared on reset so the head reads zero immediately
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE_LVL) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE_LVL) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_vld_o = (count_q != '0);
   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

endmodule

// File: rtl/candy_if_prefetch.sv
// Instruction fetch with one SRAM read in flight and up to DEPTH instructions prefetched.
// Latency: data_ready at cycle k -> instruction at the FIFO head from k+1; next request issued at k+1.
// Backpressure: inst_ready low fills the FIFO; a request is only issued when a slot is reserved for it.
module candy_if_prefetch
   import candy_if_prefetch_pkg::*;
#(
   parameter int                ADDR_W   = SRAM_ADDR_WIDTH,
   parameter int                DATA_W   = SRAM_DATA_WIDTH,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_enable,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_pc,
   output logic                   sram_read_enable,
   output logic [ADDR_W-1:0]      sram_addr,
   input  logic                   data_ready,
   input  logic [DATA_W-1:0]      sram_data,
   output logic                   inst_valid,
   output logic [DATA_W-1:0]      inst,
   output logic [ADDR_W-1:0]      inst_pc,
   input  logic                   inst_ready,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   if_state_e         state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] fetch_pc_inc;
   logic [ADDR_W-1:0] sram_addr_q;
   logic              req_q;

   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  cnt_after_pop;
   logic [CNT_W-1:0]  cnt_after_push;
   logic              room_idle;
   logic              room_push;
   logic [ADDR_W+DATA_W-1:0] head_dat;

   // Redirect squashes both FIFO ports in its cycle: the FIFO is being cleared anyway
   assign push = (state_q == IF_FETCH) && data_ready && !redirect;
   assign pop  = inst_valid && inst_ready && !redirect;

   // Occupancy seen by the issue decision: this cycle's pop is credited, and a
   // completing request counts as the slot it had reserved
   assign cnt_after_pop  = fifo_count - CNT_W'(pop);
   assign cnt_after_push = cnt_after_pop + 1'b1;
   assign room_idle      = if_enable && (cnt_after_pop < FULL_CNT);
   assign room_push      = if_enable && (cnt_after_push < FULL_CNT);

   // Sequential fetch address wraps modulo 2^ADDR_W
   assign fetch_pc_inc = fetch_pc_q + 1'b1;

   // Fetch FSM with registered SRAM request outputs; redirect overrides every state
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE_LVL) begin
         state_q     <= IF_IDLE;
         fetch_pc_q  <= RESET_PC;
         req_q       <= READ_DISABLE;
         sram_addr_q <= '0;
      end else if (redirect) begin
         fetch_pc_q <= redirect_pc;
         if ((state_q == IF_IDLE) || data_ready) begin
            // Nothing left in flight: the FIFO is empty after the clear, so only enable gates issue
            if (if_enable) begin
               state_q     <= IF_FETCH;
               req_q       <= READ_ENABLE;
               sram_addr_q <= redirect_pc;
            end else begin
               state_q <= IF_IDLE;
               req_q   <= READ_DISABLE;
            end
         end else begin
            // A request cannot be aborted; keep it on the bus and drop its data later
            state_q <= IF_DISCARD;
         end
      end else begin
         case (state_q)
            IF_IDLE: begin
               if (room_idle) begin
                  state_q     <= IF_FETCH;
                  req_q       <= READ_ENABLE;
                  sram_addr_q <= fetch_pc_q;
               end
            end
            IF_FETCH: begin
               if (data_ready) begin
                  fetch_pc_q <= fetch_pc_inc;
                  if (room_push) begin
                     sram_addr_q <= fetch_pc_inc;
                  end else begin
                     state_q <= IF_IDLE;
                     req_q   <= READ_DISABLE;
                  end
               end
            end
            IF_DISCARD: begin
               if (data_ready) begin
                  if (room_idle) begin
                     state_q     <= IF_FETCH;
                     req_q       <= READ_ENABLE;
                     sram_addr_q <= fetch_pc_q;
                  end else begin
                     state_q <= IF_IDLE;
                     req_q   <= READ_DISABLE;
                  end
               end
            end
            default: begin
               state_q <= IF_IDLE;
               req_q   <= READ_DISABLE;
            end
         endcase
      end
   end

   assign sram_read_enable = req_q;
   assign sram_addr        = sram_addr_q;

   candy_if_prefetch_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (redirect),
      .push_i     (push),
      .push_dat_i ({fetch_pc_q, sram_data}),
      .pop_i      (pop),
      .head_vld_o (inst_valid),
      .head_dat_o (head_dat),
      .count_o    (fifo_count)
   );

   assign inst_pc = head_dat[ADDR_W+DATA_W-1:DATA_W];
   assign inst    = head_dat[DATA_W-1:0];

endmodule
